key_move_mapper: RTL and testbench

Parametrised keyboard-to-move mapper for the player clients. It consumes the keyboard decoder's key_down / last_change / key_valid outputs and produces one registered move code per player from a configurable key map. The newest press wins, and on release the code falls back to a key that is still held. It also produces a per-player move pulse with optional auto-repeat, which feeds the client's move transmitter and LED status.

---
 rtl/key_move_mapper.sv | 124 ++++++++++++
 tb/tb_key_move_mapper.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/key_move_mapper.sv
// Maps keyboard decoder events to one registered move code per player, with newest-press-wins
// and fallback to a still-held key. Optional auto-repeat pulses are built when KEY_REPEAT_EN is defined.
module key_move_mapper #(
    parameter int NUM_PLAYERS = 2,
    parameter int KEYS = 4,
    parameter int CODE_W = 3,
    parameter logic [NUM_PLAYERS*KEYS*9-1:0] KEYMAP = {9'h1D, 9'h1B, 9'h1C, 9'h23,
                                                       9'h75, 9'h72, 9'h6B, 9'h74},
    parameter int REPEAT_CYCLES = 25_000_000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [511:0]                  key_down,
    input  logic [8:0]                    last_change,
    input  logic                          key_valid,
    output logic [NUM_PLAYERS*CODE_W-1:0] player_m,
    output logic [NUM_PLAYERS-1:0]        move_pulse
);

    if (REPEAT_CYCLES < 2 || (1 << CODE_W) <= KEYS) begin : g_bad_cfg
        $error("key_move_mapper: REPEAT_CYCLES must be >= 2 and 2**CODE_W must exceed KEYS");
    end

    // Player 0 / key 0 sits in the most significant 9 bits of KEYMAP.
    function automatic logic [8:0] code_of(input int p, input int k);
        return KEYMAP[(NUM_PLAYERS*KEYS-1-(p*KEYS+k))*9 +: 9];
    endfunction

    logic [CODE_W-1:0] act      [NUM_PLAYERS];
    logic [CODE_W-1:0] act_next [NUM_PLAYERS];
    logic [KEYS-1:0]   held_vec [NUM_PLAYERS];
    logic              hit      [NUM_PLAYERS];
    logic [CODE_W-1:0] hit_code [NUM_PLAYERS];
    logic [CODE_W-1:0] fb_code  [NUM_PLAYERS];
    logic              act_held [NUM_PLAYERS];
    logic              is_press;

    assign is_press = key_down[last_change];

    always_comb begin
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            held_vec[p] = '0;
            hit[p]      = 1'b0;
            hit_code[p] = '0;
            fb_code[p]  = '0;
            act_held[p] = 1'b0;
            for (int k = 0; k < KEYS; k++) begin
                held_vec[p][k] = key_down[code_of(p, k)];
                if (key_valid && last_change == code_of(p, k)) begin
                    hit[p]      = 1'b1;
                    hit_code[p] = CODE_W'(k + 1);
                end
                if (act[p] == CODE_W'(k + 1)) act_held[p] = held_vec[p][k];
            end
            // Descending scan leaves the lowest-index held key as the fallback.
            for (int k = KEYS - 1; k >= 0; k--) begin
                if (held_vec[p][k]) fb_code[p] = CODE_W'(k + 1);
            end

            act_next[p] = act[p];
            if (hit[p]) begin
                if (is_press) act_next[p] = hit_code[p];
                else if (act[p] == hit_code[p]) act_next[p] = fb_code[p];
            end else if (act[p] != '0 && !act_held[p]) begin
                // Active key vanished without a break event: recover from key_down.
                act_next[p] = fb_code[p];
            end
        end
    end

    always_comb begin
        player_m = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) player_m[p*CODE_W +: CODE_W] = act[p];
    end

`ifdef KEY_REPEAT_EN
    localparam int CNT_W = $clog2(REPEAT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REPEAT_CYCLES - 1);
    logic [CNT_W-1:0] cnt [NUM_PLAYERS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            move_pulse <= '0;
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                act[p] <= '0;
                cnt[p] <= '0;
            end
        end else begin
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                act[p] <= act_next[p];
                // A key change takes priority over a simultaneous counter wrap.
                if (act_next[p] != act[p]) begin
                    cnt[p]        <= '0;
                    move_pulse[p] <= (act_next[p] != '0);
                end else if (act[p] != '0) begin
                    if (cnt[p] == CNT_LAST) begin
                        cnt[p]        <= '0;
                        move_pulse[p] <= 1'b1;
                    end else begin
                        cnt[p]        <= cnt[p] + 1'b1;
                        move_pulse[p] <= 1'b0;
                    end
                end else begin
                    cnt[p]        <= '0;
                    move_pulse[p] <= 1'b0;
                end
            end
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            move_pulse <= '0;
            for (int p = 0; p < NUM_PLAYERS; p++) act[p] <= '0;
        end else begin
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                act[p]        <= act_next[p];
                move_pulse[p] <= (act_next[p] != act[p]) && (act_next[p] != '0);
            end
        end
    end
`endif

endmodule

// File: tb/tb_key_move_mapper.sv
// Bench for key_move_mapper: directed scenarios plus random key traffic, checked through an
// expected-response queue against a cycle-level model of the mapping rules.
module tb_key_move_mapper;
    localparam int NP = 2;
    localparam int K  = 4;
    localparam int CW = 3;
    localparam int RC = 4;
    localparam logic [NP*K*9-1:0] MAP = {9'h1D, 9'h1B, 9'h1C, 9'h23,
                                         9'h75, 9'h72, 9'h6B, 9'h74};
    localparam int EW = NP*CW + NP;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [511:0] key_down = '0;
    logic [8:0] last_change = '0;
    logic key_valid = 1'b0;
    logic [NP*CW-1:0] player_m;
    logic [NP-1:0] move_pulse;

    key_move_mapper #(
        .NUM_PLAYERS(NP), .KEYS(K), .CODE_W(CW), .KEYMAP(MAP), .REPEAT_CYCLES(RC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .key_down(key_down), .last_change(last_change),
        .key_valid(key_valid), .player_m(player_m), .move_pulse(move_pulse)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [EW-1:0] exp_q[$];
    int tests = 0;
    int fails = 0;
    int m_act[NP];
    int m_age[NP];

    function automatic logic [8:0] code_of(input int p, input int k);
        logic [NP*K*9-1:0] m;
        m = MAP;
        return m[(NP*K-1-(p*K+k))*9 +: 9];
    endfunction

    task automatic model_reset();
        for (int p = 0; p < NP; p++) begin
            m_act[p] = 0;
            m_age[p] = 0;
        end
    endtask

    // Expected outputs after the coming clock edge, from the current inputs.
    task automatic model_step(output logic [EW-1:0] e);
        logic [NP*CW-1:0] pm;
        logic [NP-1:0] mp;
        pm = '0;
        mp = '0;
        for (int p = 0; p < NP; p++) begin
            int a, nw, low, kidx;
            logic pulse;
            a = m_act[p];
            low = 0;
            kidx = -1;
            for (int k = K - 1; k >= 0; k--) if (key_down[code_of(p, k)]) low = k + 1;
            for (int k = 0; k < K; k++) if (key_valid && last_change == code_of(p, k)) kidx = k;
            nw = a;
            if (kidx >= 0) begin
                if (key_down[last_change]) nw = kidx + 1;
                else if (a == kidx + 1) nw = low;
            end else if (a != 0 && !key_down[code_of(p, a - 1)]) begin
                nw = low;
            end
            pulse = 1'b0;
            if (nw != a) begin
                m_age[p] = 0;
                pulse = (nw != 0);
            end else if (nw != 0) begin
                m_age[p]++;
`ifdef KEY_REPEAT_EN
                if (m_age[p] % RC == 0) pulse = 1'b1;
`endif
            end
            m_act[p] = nw;
            pm[p*CW +: CW] = CW'(nw);
            mp[p] = pulse;
        end
        e = {pm, mp};
    endtask

    // ---------------- driver tasks ----------------
    task automatic ev(input logic [8:0] c, input logic down, input logic kv);
        logic [EW-1:0] e;
        @(negedge clk);
        key_down[c] = down;
        key_valid = kv;
        last_change = c;
        model_step(e);
        exp_q.push_back(e);
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        logic [EW-1:0] e;
        repeat (n) begin
            @(negedge clk);
            key_valid = 1'b0;
            last_change = 9'($urandom_range(0, 511));
            model_step(e);
            exp_q.push_back(e);
            @(posedge clk);
        end
    endtask

    task automatic check_zero(input string name);
        tests++;
        if (player_m !== '0 || move_pulse !== '0) begin
            fails++;
            $display("FAIL %s: player_m=%h move_pulse=%b, required 0/0", name, player_m, move_pulse);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(posedge clk) begin
        logic [EW-1:0] e;
        #2;
        if (rst_n && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if (player_m !== e[EW-1:NP]) begin
                fails++;
                $display("FAIL player_m @%0t: got %h, required %h", $time, player_m, e[EW-1:NP]);
            end
            tests++;
            if (move_pulse !== e[NP-1:0]) begin
                fails++;
                $display("FAIL move_pulse @%0t: got %b, required %b", $time, move_pulse, e[NP-1:0]);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [8:0] unmapped[4];
        unmapped = '{9'h029, 9'h045, 9'h1F0, 9'h000};
        model_reset();
        repeat (2) @(posedge clk);
        #1 check_zero("reset_state");
        @(negedge clk) rst_n = 1'b1;

        // single press / release
        ev(9'h1D, 1, 1); idle(2); ev(9'h1D, 0, 1); idle(2);
        // newest wins, fallback to held key
        ev(9'h1D, 1, 1); idle(1); ev(9'h1B, 1, 1); idle(1);
        ev(9'h1B, 0, 1); idle(1); ev(9'h1D, 0, 1); idle(1);
        // two players at once
        ev(9'h75, 1, 1); ev(9'h1C, 1, 1); idle(2); ev(9'h75, 0, 1); ev(9'h1C, 0, 1);
        // long hold, then switch mid-repeat, then fall back
        ev(9'h72, 1, 1); idle(5); ev(9'h6B, 1, 1); idle(7);
        ev(9'h6B, 0, 1); idle(2); ev(9'h72, 0, 1);
        // silent key_down clear and unmapped code
        ev(9'h23, 1, 1); idle(1); ev(9'h23, 0, 0); idle(1);
        ev(9'h029, 1, 1); idle(1); ev(9'h029, 0, 1); idle(1);

        // asynchronous reset during a hold with a repeat pending
        ev(9'h72, 1, 1); idle(2);
        #3 rst_n = 1'b0;
        #1 check_zero("async_reset");
        model_reset();
        repeat (3) @(posedge clk);
        #1 check_zero("reset_held");
        @(negedge clk) rst_n = 1'b1;
        idle(8);
        ev(9'h72, 0, 1);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            int r;
            logic [8:0] c;
            r = $urandom_range(0, 11);
            c = code_of($urandom_range(0, NP - 1), $urandom_range(0, K - 1));
            case (r)
                0, 1, 2, 3: ev(c, 1, 1);
                4, 5, 6:    ev(c, 0, 1);
                7:          ev(c, 0, 0);
                8:          ev(unmapped[$urandom_range(0, 3)], 1'($urandom_range(0, 1)), 1);
                9:          ev(c, 1, 0);
                default:    idle($urandom_range(1, 6));
            endcase
        end
        idle(2);

        repeat (2) @(posedge clk);
        #3;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL queue_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
